// File: rtl/char_stream.sv
// Byte stream front end: FIFO plus registered output stage feeding a day solver, with counters.
// Optional macro CHAR_STREAM_CR_STRIP_EN drops 8'h0D bytes at the input.
module char_stream #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_char,
    input  logic        in_last,
    input  logic        restart,
    output logic [7:0]  out_char,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] char_count,
    output logic [15:0] line_count,
    output logic        done
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    state_t          state, state_nxt;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic            empty, full, in_hs, out_hs, wr_en, rd_en;

    // One slot is kept open so full/empty need no extra pointer bit;
    // the output register makes up the difference in total buffering.
    assign empty  = (wptr == rptr);
    assign full   = ((wptr + AW'(1)) == rptr);
    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;
    assign rd_en  = !empty && (!out_valid || out_ready);

`ifdef CHAR_STREAM_CR_STRIP_EN
    assign wr_en = in_hs && (in_char != 8'h0D);
`else
    assign wr_en = in_hs;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       state <= IDLE;
        else if (restart) state <= IDLE;
        else              state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_hs) state_nxt = in_last ? DRAIN : STREAM;
            STREAM:  if (in_hs && in_last) state_nxt = DRAIN;
            DRAIN:   if (empty && (!out_valid || out_ready)) state_nxt = DONE;
            default: state_nxt = DONE;
        endcase
    end

    // rst_n gates in_ready so it reads 0 while reset is held.
    always_comb begin
        in_ready = rst_n && ((state == IDLE) || (state == STREAM)) && !full;
        done     = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= in_char;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (restart) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + AW'(1);
            if (rd_en) rptr <= rptr + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_char   <= 8'h00;
            out_valid  <= 1'b0;
            char_count <= '0;
            line_count <= '0;
        end else if (restart) begin
            out_char   <= 8'h00;
            out_valid  <= 1'b0;
            char_count <= '0;
            line_count <= '0;
        end else begin
            if (rd_en) begin
                out_char  <= mem[rptr];
                out_valid <= 1'b1;
            end else if (out_hs) begin
                out_char  <= 8'h00;
                out_valid <= 1'b0;
            end
            if (out_hs) begin
                char_count <= char_count + 32'd1;
                if (out_char == 8'h0A && line_count != 16'hFFFF)
                    line_count <= line_count + 16'd1;
            end
        end
    end
endmodule
